// File: rtl/mux_pkg.sv
// Shared widths and types for the registered 8-to-1 bit selector.
// Widths are fixed; the types keep port declarations consistent across files.
package mux_pkg;

  localparam int DATA_W = 8;
  localparam int SEL_W  = 3;

  typedef logic [DATA_W-1:0] code_t;
  typedef logic [SEL_W-1:0]  sel_t;

endpackage : mux_pkg

// File: rtl/mux_2_1.sv
// Single-bit 2-to-1 multiplexer leaf: y follows b when s is high, a otherwise.
// Purely combinational; the parent module supplies any registering.
module mux_2_1 (
  input  logic a,
  input  logic b,
  input  logic s,
  output logic y
);

  assign y = s ? b : a;

endmodule : mux_2_1

// File: rtl/mux_8_1_v_behavior.sv
// Registered 8-to-1 bit selector: o_f takes i_code[i_sel_code] one clock later.
// Built as a three-level tree of 2-to-1 leaves, one select bit per level, LSB first.
module mux_8_1_v_behavior
  import mux_pkg::*;
(
  input  logic  i_clk,
  input  logic  i_rst,
  input  code_t i_code,
  input  sel_t  i_sel_code,
  output logic  o_f
);

  logic [3:0] lvl0;
  logic [1:0] lvl1;
  logic       f;

  // Level 0 resolves sel bit 0 across adjacent pairs (0,1)(2,3)(4,5)(6,7).
  for (genvar i = 0; i < 4; i++) begin : g_lvl0
    mux_2_1 u_mux (
      .a (i_code[2*i]),
      .b (i_code[2*i+1]),
      .s (i_sel_code[0]),
      .y (lvl0[i])
    );
  end

  for (genvar i = 0; i < 2; i++) begin : g_lvl1
    mux_2_1 u_mux (
      .a (lvl0[2*i]),
      .b (lvl0[2*i+1]),
      .s (i_sel_code[1]),
      .y (lvl1[i])
    );
  end

  mux_2_1 u_lvl2 (
    .a (lvl1[0]),
    .b (lvl1[1]),
    .s (i_sel_code[2]),
    .y (f)
  );

  // NOTE: sequential state uses non-blocking assignment so every flop samples
  // pre-edge values; reset is synchronous and takes priority over data.
  always_ff @(posedge i_clk) begin
    if (i_rst) o_f <= 1'b0;
    else       o_f <= f;
  end

endmodule : mux_8_1_v_behavior

// File: tb/tb_mux_8_1_v_behavior.sv
// Self-checking bench for mux_8_1_v_behavior: directed vector table plus an
// exhaustive sweep with a one-cycle-delayed scoreboard and a mid-stream reset.
module tb_mux_8_1_v_behavior;
  import mux_pkg::*;

  logic  clk;
  logic  rst;
  code_t code;
  sel_t  sel;
  logic  f;

  int checks = 0;
  int errors = 0;

  typedef struct {
    code_t code;
    sel_t  sel;
    logic  rst;
    logic  exp;
  } vec_t;

  vec_t vecs[$];

  mux_8_1_v_behavior dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_code     (code),
    .i_sel_code (sel),
    .o_f        (f)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not reach summary (actual running, required finished)");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic actual, input logic expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %b, expected %b", name, actual, expected);
    end
  endtask

  // Drive inputs away from the edge, clock once, sample just after the edge.
  task automatic step(input code_t c, input sel_t s, input logic r);
    @(negedge clk);
    code = c;
    sel  = s;
    rst  = r;
    @(posedge clk);
    #1;
  endtask

  task automatic add(input code_t c, input sel_t s, input logic r, input logic e);
    vec_t v;
    v.code = c;
    v.sel  = s;
    v.rst  = r;
    v.exp  = e;
    vecs.push_back(v);
  endtask

  initial begin
    code_t c;
    sel_t  s;
    logic  a5_seq [8];
    logic  exp_prev;
    logic  exp_now;

    code = '0;
    sel  = '0;
    rst  = 1'b1;

    // Reset held for two edges with all-ones data, then release.
    add(8'hFF, 3'd7, 1'b1, 1'b0);
    add(8'hFF, 3'd7, 1'b1, 1'b0);
    add(8'hFF, 3'd7, 1'b0, 1'b1);

    // Walking one: matching select gives 1, neighbouring select gives 0.
    for (int n = 0; n < 8; n++) begin
      c = 8'h01 << n;
      s = 3'(n);
      add(c, s, 1'b0, 1'b1);
      s = 3'((n + 1) % 8);
      add(c, s, 1'b0, 1'b0);
    end

    // Walking zero: only the cleared bit reads back as 0.
    for (int n = 0; n < 8; n++) begin
      c = ~(8'h01 << n);
      for (int k = 0; k < 8; k++) begin
        s = 3'(k);
        add(c, s, 1'b0, (k == n) ? 1'b0 : 1'b1);
      end
    end

    // 8'hA5 = 1010_0101, bits 0..7.
    a5_seq = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    for (int k = 0; k < 8; k++) begin
      s = 3'(k);
      add(8'hA5, s, 1'b0, a5_seq[k]);
    end

    // Reset with data that would otherwise select a 1, then immediate recovery.
    add(8'h80, 3'd7, 1'b1, 1'b0);
    add(8'h80, 3'd7, 1'b0, 1'b1);
    // Data and select change together.
    add(8'h40, 3'd6, 1'b0, 1'b1);
    add(8'h02, 3'd0, 1'b0, 1'b0);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].code, vecs[i].sel, vecs[i].rst);
      check($sformatf("vec%0d code=%02h sel=%0d rst=%b", i, vecs[i].code, vecs[i].sel, vecs[i].rst),
            f, vecs[i].exp);
    end

    // Exhaustive sweep with a single-cycle reset pulse at count 1000.
    for (int cnt = 0; cnt < 2048; cnt++) begin
      logic [10:0] cv;
      logic        r;
      cv = 11'(cnt);
      r  = (cnt == 1000);
      c  = cv[7:0];
      s  = cv[10:8];
      exp_now = r ? 1'b0 : c[s];
      step(c, s, r);
      check($sformatf("sweep cnt=%0d code=%02h sel=%0d rst=%b", cnt, c, s, r), f, exp_now);
      exp_prev = exp_now;
    end

    // Hold inputs one more edge: output must track the last sample, not drift.
    step(8'hFF, 3'd7, 1'b0);
    check("post_sweep_hold", f, 1'b1);
    step(8'hFF, 3'd7, 1'b1);
    check("final_reset", f, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_mux_8_1_v_behavior
